// File: rtl/frame_buf_ctrl.sv
// Multi-slot frame-buffer address controller: a writer fills free slots and a
// reader drains completed slots in order, so a frame is never read while being written.
module frame_buf_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int BASE_ADDR   = 2,
    parameter int FRAME_SIZE  = 4,
    parameter int NUM_BUFS    = 3,
    parameter int REPEAT_LAST = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en_in,
    input  logic                           rd_en_in,
    input  logic                           wr_rdy,
    input  logic                           rd_rdy,
    output logic                           wr_en,
    output logic                           rd_en,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [$clog2(NUM_BUFS+1)-1:0]  frames_full,
    output logic                           wr_ovf,
    output logic                           rd_unf,
    output logic                           rd_frame_start
);

    localparam int CW = $clog2(FRAME_SIZE);
    localparam int SW = $clog2(NUM_BUFS);
    localparam int FW = $clog2(NUM_BUFS + 1);

    localparam logic [CW-1:0]         LAST_WORD = CW'(FRAME_SIZE - 1);
    localparam logic [SW-1:0]         LAST_SLOT = SW'(NUM_BUFS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(FRAME_SIZE);

    typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_READ = 1'b1} r_state_t;

    w_state_t              w_state_r, w_state_s;
    r_state_t              r_state_r, r_state_s;
    logic [CW-1:0]         wr_cnt_r, wr_cnt_s, rd_cnt_r, rd_cnt_s;
    logic [SW-1:0]         wr_slot_r, wr_slot_s, rd_slot_r, rd_slot_s, rd_next_slot_s;
    logic [ADDR_WIDTH-1:0] wr_base_r, wr_base_s, rd_base_r, rd_base_s, rd_next_base_s;
    logic [NUM_BUFS-1:0]   full_r, full_s;
    logic [FW-1:0]         frames_full_s;
    logic                  wr_en_s, rd_en_s, wr_ovf_s, rd_unf_s, rd_frame_start_s;
    logic                  wr_done_s, rd_release_s;
    logic                  wr_accept_s, rd_accept_s;

    assign wr_accept_s = ~wr_en & wr_rdy;
    assign rd_accept_s = ~rd_en & rd_rdy;

    // Writer: claim a free slot, stream one frame, mark it full and advance.
    always_comb begin
        w_state_s = w_state_r;
        wr_en_s   = 1'b1;
        wr_cnt_s  = wr_cnt_r;
        wr_slot_s = wr_slot_r;
        wr_base_s = wr_base_r;
        wr_ovf_s  = wr_ovf;
        wr_done_s = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (!wr_en_in) begin
                    if (!full_r[wr_slot_r]) begin
                        w_state_s = W_FILL;
                        wr_en_s   = 1'b0;
                    end else begin
                        wr_ovf_s  = 1'b1;
                    end
                end else begin
                    wr_en_s = 1'b1;
                end
            end
            W_FILL: begin
                wr_en_s = wr_en_in;
                if (wr_accept_s) begin
                    if (wr_cnt_r == LAST_WORD) begin
                        wr_done_s = 1'b1;
                        wr_en_s   = 1'b1;
                        wr_cnt_s  = {CW{1'b0}};
                        w_state_s = W_IDLE;
                        if (wr_slot_r == LAST_SLOT) begin
                            wr_slot_s = {SW{1'b0}};
                            wr_base_s = BASE;
                        end else begin
                            wr_slot_s = wr_slot_r + {{(SW-1){1'b0}}, 1'b1};
                            wr_base_s = wr_base_r + STEP;
                        end
                    end else begin
                        wr_cnt_s = wr_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    wr_cnt_s = wr_cnt_r;
                end
            end
            default: begin
                w_state_s = W_IDLE;
            end
        endcase
    end

    // Slot that follows the reader's current slot, with wrap to the first slot.
    always_comb begin
        if (rd_slot_r == LAST_SLOT) begin
            rd_next_slot_s = {SW{1'b0}};
            rd_next_base_s = BASE;
        end else begin
            rd_next_slot_s = rd_slot_r + {{(SW-1){1'b0}}, 1'b1};
            rd_next_base_s = rd_base_r + STEP;
        end
    end

    // Reader: only enters a full slot; at frame end releases it or, in repeat mode, re-reads it.
    always_comb begin
        r_state_s        = r_state_r;
        rd_en_s          = 1'b1;
        rd_cnt_s         = rd_cnt_r;
        rd_slot_s        = rd_slot_r;
        rd_base_s        = rd_base_r;
        rd_unf_s         = rd_unf;
        rd_frame_start_s = 1'b0;
        rd_release_s     = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (!rd_en_in) begin
                    if (full_r[rd_slot_r]) begin
                        r_state_s        = R_READ;
                        rd_en_s          = 1'b0;
                        rd_frame_start_s = 1'b1;
                    end else begin
                        rd_unf_s = 1'b1;
                    end
                end else begin
                    rd_en_s = 1'b1;
                end
            end
            R_READ: begin
                rd_en_s = rd_en_in;
                if (rd_accept_s) begin
                    if (rd_cnt_r == LAST_WORD) begin
                        rd_en_s   = 1'b1;
                        rd_cnt_s  = {CW{1'b0}};
                        r_state_s = R_IDLE;
                        if (full_r[rd_next_slot_s] || (REPEAT_LAST == 0)) begin
                            rd_release_s = 1'b1;
                            rd_slot_s    = rd_next_slot_s;
                            rd_base_s    = rd_next_base_s;
                        end else begin
                            rd_slot_s = rd_slot_r;
                        end
                    end else begin
                        rd_cnt_s = rd_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    rd_cnt_s = rd_cnt_r;
                end
            end
            default: begin
                r_state_s = R_IDLE;
            end
        endcase
    end

    // Full flags and count; writer and reader always touch different slots.
    always_comb begin
        full_s = full_r;
        if (wr_done_s) begin
            full_s[wr_slot_r] = 1'b1;
        end else begin
            full_s = full_s;
        end
        if (rd_release_s) begin
            full_s[rd_slot_r] = 1'b0;
        end else begin
            full_s = full_s;
        end
        case ({wr_done_s, rd_release_s})
            2'b10:   frames_full_s = frames_full + {{(FW-1){1'b0}}, 1'b1};
            2'b01:   frames_full_s = frames_full - {{(FW-1){1'b0}}, 1'b1};
            default: frames_full_s = frames_full;
        endcase
    end

    // State and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_state_r      <= W_IDLE;
            r_state_r      <= R_IDLE;
            wr_cnt_r       <= {CW{1'b0}};
            rd_cnt_r       <= {CW{1'b0}};
            wr_slot_r      <= {SW{1'b0}};
            rd_slot_r      <= {SW{1'b0}};
            wr_base_r      <= BASE;
            rd_base_r      <= BASE;
            full_r         <= {NUM_BUFS{1'b0}};
            frames_full    <= {FW{1'b0}};
            wr_en          <= 1'b1;
            rd_en          <= 1'b1;
            wr_addr        <= BASE;
            rd_addr        <= BASE;
            wr_ovf         <= 1'b0;
            rd_unf         <= 1'b0;
            rd_frame_start <= 1'b0;
        end else begin
            w_state_r      <= w_state_s;
            r_state_r      <= r_state_s;
            wr_cnt_r       <= wr_cnt_s;
            rd_cnt_r       <= rd_cnt_s;
            wr_slot_r      <= wr_slot_s;
            rd_slot_r      <= rd_slot_s;
            wr_base_r      <= wr_base_s;
            rd_base_r      <= rd_base_s;
            full_r         <= full_s;
            frames_full    <= frames_full_s;
            wr_en          <= wr_en_s;
            rd_en          <= rd_en_s;
            wr_addr        <= wr_base_s + ADDR_WIDTH'(wr_cnt_s);
            rd_addr        <= rd_base_s + ADDR_WIDTH'(rd_cnt_s);
            wr_ovf         <= wr_ovf_s;
            rd_unf         <= rd_unf_s;
            rd_frame_start <= rd_frame_start_s;
        end
    end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Table-driven bench: dut_a uses defaults, dut_b has REPEAT_LAST=1; expected
// outputs are queued when a vector is driven and checked after the clock edge.
module tb_frame_buf_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_reset, a_wi, a_ri, a_wy, a_ry;
    logic a_we, a_re, a_ovf, a_unf, a_fs;
    logic [7:0] a_wa, a_ra;
    logic [1:0] a_ff;

    logic b_reset, b_wi, b_ri, b_wy, b_ry;
    logic b_we, b_re, b_ovf, b_unf, b_fs;
    logic [7:0] b_wa, b_ra;
    logic [1:0] b_ff;

    frame_buf_ctrl dut_a (
        .clk(clk), .reset(a_reset), .wr_en_in(a_wi), .rd_en_in(a_ri),
        .wr_rdy(a_wy), .rd_rdy(a_ry), .wr_en(a_we), .rd_en(a_re),
        .wr_addr(a_wa), .rd_addr(a_ra), .frames_full(a_ff),
        .wr_ovf(a_ovf), .rd_unf(a_unf), .rd_frame_start(a_fs)
    );

    frame_buf_ctrl #(.REPEAT_LAST(1)) dut_b (
        .clk(clk), .reset(b_reset), .wr_en_in(b_wi), .rd_en_in(b_ri),
        .wr_rdy(b_wy), .rd_rdy(b_ry), .wr_en(b_we), .rd_en(b_re),
        .wr_addr(b_wa), .rd_addr(b_ra), .frames_full(b_ff),
        .wr_ovf(b_ovf), .rd_unf(b_unf), .rd_frame_start(b_fs)
    );

    typedef struct {
        logic       sel;
        logic       rst, wi, ri, wy, ry;
        logic       we, re;
        logic [7:0] wa, ra;
        logic [1:0] ff;
        logic       ovf, unf, fs;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t v(logic sel, logic rst, logic wi, logic ri, logic wy, logic ry,
                               logic we, logic re, logic [7:0] wa, logic [7:0] ra,
                               logic [1:0] ff, logic ovf, logic unf, logic fs);
        vec_t r;
        r.sel = sel; r.rst = rst; r.wi = wi; r.ri = ri; r.wy = wy; r.ry = ry;
        r.we = we; r.re = re; r.wa = wa; r.ra = ra; r.ff = ff;
        r.ovf = ovf; r.unf = unf; r.fs = fs;
        return r;
    endfunction

    // Watchdog: flag a failure if the run does not finish in bounded time.
    initial begin
        #100000;
        n_bad++;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        vec_t       cur, e;
        logic [22:0] got, want;

        a_reset = 1'b0; a_wi = 1'b1; a_ri = 1'b1; a_wy = 1'b0; a_ry = 1'b0;
        b_reset = 1'b0; b_wi = 1'b1; b_ri = 1'b1; b_wy = 1'b0; b_ry = 1'b0;

        // dut_a: reset, aborted frame, three frames, overflow, reads, stalls, underrun
        //              sel rst wi ri wy ry   we re wa     ra    ff   ovf unf fs
        vecs.push_back(v(0, 0, 1, 1, 0, 0,   1, 1, 8'd2,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd2,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd3,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd4,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 1, 0,   1, 1, 8'd2,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd2,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd3,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd4,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd5,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   1, 1, 8'd6,  8'd2, 2'd1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd6,  8'd2, 2'd1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd7,  8'd2, 2'd1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 0, 0,   0, 1, 8'd7,  8'd2, 2'd1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 0, 0,   0, 1, 8'd7,  8'd2, 2'd1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd8,  8'd2, 2'd1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd9,  8'd2, 2'd1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   1, 1, 8'd10, 8'd2, 2'd2, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd10, 8'd2, 2'd2, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd11, 8'd2, 2'd2, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd12, 8'd2, 2'd2, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   0, 1, 8'd13, 8'd2, 2'd2, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   1, 1, 8'd2,  8'd2, 2'd3, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   1, 1, 8'd2,  8'd2, 2'd3, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 1, 1, 0,   1, 1, 8'd2,  8'd2, 2'd3, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   1, 0, 8'd2,  8'd2, 2'd3, 1, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   1, 0, 8'd2,  8'd3, 2'd3, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   1, 0, 8'd2,  8'd4, 2'd3, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   1, 0, 8'd2,  8'd5, 2'd3, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   1, 1, 8'd2,  8'd6, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   0, 0, 8'd2,  8'd6, 2'd2, 1, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   0, 0, 8'd3,  8'd7, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   0, 0, 8'd4,  8'd8, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   0, 0, 8'd5,  8'd9, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 1,   1, 1, 8'd6,  8'd10, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd10, 2'd2, 1, 0, 1));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd11, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd12, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd13, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 1, 8'd6,  8'd2, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd2, 2'd1, 1, 0, 1));
        vecs.push_back(v(0, 1, 1, 0, 1, 0,   1, 0, 8'd6,  8'd2, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 0,   1, 0, 8'd6,  8'd2, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd3, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd4, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd5, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 1, 8'd6,  8'd6, 2'd0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 1, 1,   1, 1, 8'd6,  8'd6, 2'd0, 1, 1, 0));
        vecs.push_back(v(0, 0, 1, 1, 0, 0,   1, 1, 8'd2,  8'd2, 2'd0, 0, 0, 0));

        // dut_b (repeat mode): frame re-read until slot 1 completes mid second pass
        vecs.push_back(v(1, 0, 1, 1, 0, 0,   1, 1, 8'd2,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 0,   0, 1, 8'd2,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 0,   0, 1, 8'd3,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 0,   0, 1, 8'd4,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 0,   0, 1, 8'd5,  8'd2, 2'd0, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 1, 0,   1, 1, 8'd6,  8'd2, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd2, 2'd1, 0, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd3, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 0, 8'd6,  8'd4, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 1, 1,   0, 0, 8'd6,  8'd5, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 1, 1,   0, 1, 8'd7,  8'd2, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 1, 1,   0, 0, 8'd8,  8'd2, 2'd1, 0, 0, 1));
        vecs.push_back(v(1, 1, 0, 0, 1, 1,   0, 0, 8'd9,  8'd3, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 1, 1,   1, 0, 8'd10, 8'd4, 2'd2, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 0, 8'd10, 8'd5, 2'd2, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 1, 8'd10, 8'd6, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 0, 8'd10, 8'd6, 2'd1, 0, 0, 1));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 0, 8'd10, 8'd7, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 0, 8'd10, 8'd8, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 0, 8'd10, 8'd9, 2'd1, 0, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 1, 1,   1, 1, 8'd10, 8'd6, 2'd1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cur = vecs[i];
            @(negedge clk);
            if (cur.sel == 1'b0) begin
                a_reset = cur.rst; a_wi = cur.wi; a_ri = cur.ri; a_wy = cur.wy; a_ry = cur.ry;
            end else begin
                a_reset = 1'b1; a_wi = 1'b1; a_ri = 1'b1; a_wy = 1'b0; a_ry = 1'b0;
                b_reset = cur.rst; b_wi = cur.wi; b_ri = cur.ri; b_wy = cur.wy; b_ry = cur.ry;
            end
            exp_q.push_back(cur);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if (e.sel == 1'b0) begin
                got = {a_we, a_re, a_wa, a_ra, a_ff, a_ovf, a_unf, a_fs};
            end else begin
                got = {b_we, b_re, b_wa, b_ra, b_ff, b_ovf, b_unf, b_fs};
            end
            want = {e.we, e.re, e.wa, e.ra, e.ff, e.ovf, e.unf, e.fs};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL vec%0d dut_%s: got we=%b re=%b wa=%0d ra=%0d ff=%0d ovf=%b unf=%b fs=%b, want we=%b re=%b wa=%0d ra=%0d ff=%0d ovf=%b unf=%b fs=%b",
                         i, e.sel ? "b" : "a",
                         got[22], got[21], got[20:13], got[12:5], got[4:3], got[2], got[1], got[0],
                         e.we, e.re, e.wa, e.ra, e.ff, e.ovf, e.unf, e.fs);
            end
        end

        got  = {a_we, a_re, a_wa, a_ra, a_ff, a_ovf, a_unf, a_fs};
        want = {1'b1, 1'b1, 8'd2, 8'd2, 2'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset-state dut_a: got we=%b re=%b wa=%0d ra=%0d ff=%0d ovf=%b unf=%b fs=%b, want we=1 re=1 wa=2 ra=2 ff=0 ovf=0 unf=0 fs=0",
                     got[22], got[21], got[20:13], got[12:5], got[4:3], got[2], got[1], got[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_buf_ctrl.md
Name: frame_buf_ctrl

Overview:
- Single-clock, multi-slot frame-buffer address controller and successor to the single-buffer fill/read controller.
- Manages NUM_BUFS frame slots of FRAME_SIZE words each, laid out contiguously from BASE_ADDR in external memory. It generates write and read enables and addresses for the memory interface.
- Reader only consumes completed frames, so there is no tearing. Optional repeat-last-frame mode keeps a display fed when the source is slow.
- Adds frame-count, overflow and underrun status.

Parameters:
ADDR_WIDTH, 8, width of wr_addr/rd_addr; must hold BASE_ADDR+NUM_BUFS*FRAME_SIZE-1
BASE_ADDR, 2, address of word 0 of slot 0
FRAME_SIZE, 4, words per frame (>=2)
NUM_BUFS, 3, number of frame slots (>=2)
REPEAT_LAST, 0, 1 = reader re-reads current frame when no newer frame is complete

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-low reset
wr_en_in  in  1  active-low write request from source
rd_en_in  in  1  active-low read request from sink
wr_rdy  in  1  active-high, memory accepted write beat
rd_rdy  in  1  active-high, memory accepted read beat
wr_en  out  1  active-low write enable to memory, registered
rd_en  out  1  active-low read enable to memory, registered
wr_addr  out  ADDR_WIDTH  current write address
rd_addr  out  ADDR_WIDTH  current read address
frames_full  out  $clog2(NUM_BUFS+1)  count of completed, unreleased slots
wr_ovf  out  1  sticky: write requested while no free slot
rd_unf  out  1  sticky: read requested while no readable frame
rd_frame_start  out  1  one-cycle pulse when reader begins a frame

Behaviour:
- Reset: one clock, synchronous, active-low (reset==0 at posedge).
  - wr_en=1, rd_en=1, wr_addr=rd_addr=BASE_ADDR.
  - frames_full=0, wr_ovf=0, rd_unf=0, rd_frame_start=0.
  - All full flags cleared; wr_slot=rd_slot=0; both FSMs to IDLE.
  - Reset mid-frame aborts silently and discards partial data.
- Slot base: kept in a register per side. Advance adds FRAME_SIZE; after slot NUM_BUFS-1 it wraps to BASE_ADDR. No multiplier.
- Address: addr = slot_base + word_cnt, with word_cnt in 0..FRAME_SIZE-1.
- Beat acceptance:
  - Write beat accepted on a cycle with wr_en==0 && wr_rdy==1; read beat likewise with rd_en and rd_rdy.
  - On acceptance the address increments at the next edge.
  - With wr_rdy/rd_rdy low, the address holds.
- Writer FSM (W_IDLE, W_FILL):
  - W_IDLE: if wr_en_in==0 and full[wr_slot]==0, go to W_FILL and set wr_en=0. If wr_en_in==0 and full[wr_slot]==1, stay in W_IDLE, wr_en=1, set wr_ovf.
  - W_FILL: wr_en follows wr_en_in, registered.
  - When the beat at word_cnt==FRAME_SIZE-1 is accepted: set full[wr_slot], increment frames_full, advance wr_slot/base, word_cnt=0, wr_en=1, return to W_IDLE.
- Reader FSM (R_IDLE, R_READ):
  - R_IDLE: if rd_en_in==0 and full[rd_slot]==1, go to R_READ, rd_en=0, pulse rd_frame_start. If rd_en_in==0 and no full slot, set rd_unf.
  - R_READ: rd_en=0 only while rd_en_in==0.
  - On acceptance of the last beat, the reader checks the next slot:
    - If full[next] is set, or REPEAT_LAST==0: clear full[rd_slot], decrement frames_full, advance rd_slot/base.
    - Otherwise (REPEAT_LAST==1 and next slot not full): keep rd_slot and its full flag, and reset word_cnt to re-read the same frame.
  - In both cases return to R_IDLE with rd_en=1.
- Simultaneous events:
  - Writer completing and reader releasing in the same cycle touch different slots; both apply, and frames_full is net unchanged.
  - The writer never enters a slot flagged full, and the reader never enters one not flagged full. This guarantees no overlap.
- Latency: wr_en/rd_en assert one cycle after the qualifying request edge.
- wr_ovf and rd_unf clear only on reset.

Test Plan:
- Reset with defaults -> wr_en=1, rd_en=1, wr_addr=rd_addr=2, frames_full=0, all flags 0; repeat reset mid-frame at wr_addr=4 -> wr_addr=2 next cycle.
- Hold wr_en_in=0 with wr_rdy=1 -> wr_addr 2,3,4,5, then 6; frames_full=1; wr_en high for one cycle at frame end before refill.
- Write 3 frames (addresses 2..13), keep wr_en_in=0 -> wr_addr=2, wr_en=1, wr_ovf=1, frames_full=3; read one frame -> writer resumes at 2.
- Write one frame, then rd_en_in=0 with rd_rdy=1 -> rd_addr 2..5, rd_frame_start pulse at start, frames_full=0 after frame, next rd_addr=6, rd_unf=1 when no further frame.
- REPEAT_LAST=1, one frame written -> reader outputs 2..5 twice with frames_full=1; complete slot 1 during the second pass -> third read is 6..9, frames_full=1.
- Toggle wr_rdy/rd_rdy low for 2 cycles mid-frame -> addresses hold; writer completes slot 1 on the same cycle the reader releases slot 0 -> frames_full unchanged.
